// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment digit constants and monitor FSM state type
package seg_pkg;

  // Segment order {g,f,e,d,c,b,a}, active-high, bit0 = a
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAULT
  } seg_state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - maps one seven-segment pattern to {legal, digit}
module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  input  logic       blank_is_zero,
  output logic       legal,
  output logic [3:0] digit
);

  always_comb begin
    legal = 1'b1;
    digit = 4'd0;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: legal = blank_is_zero;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_monitor.sv
// rtl/seg_monitor.sv - debounced two-digit scoreboard monitor; SEG_MONITOR_EVENTS_EN enables inc/dec pulses
module seg_monitor
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [6:0] seg_tens_i,
  input  logic [6:0] seg_ones_i,
  output logic [6:0] score_o,
  output logic       valid_o,
  output logic       err_o,
  output logic       inc_o,
  output logic       dec_o
);

  localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 1);

  logic [13:0] sample_q;
  logic [7:0]  cnt_q;
  seg_state_t  state_q, state_d;
  logic [13:0] new_sample;
  logic        changed, accept;
  logic        tens_legal, ones_legal, legal;
  logic [3:0]  tens_digit, ones_digit;
  logic [6:0]  new_score;

  assign new_sample = {seg_tens_i, seg_ones_i};
  assign changed    = (new_sample != sample_q);
  // The register already holds the first copy, so the count of repeats reaches
  // STABLE_CYCLES-1 on the edge that sees the pattern for the last time.
  assign accept     = (state_q == ST_SETTLE) && !changed && (cnt_q == ACCEPT_CNT);

  seg7_decode u_dec_tens (
    .seg           (sample_q[13:7]),
    .blank_is_zero (1'b1),
    .legal         (tens_legal),
    .digit         (tens_digit)
  );

  seg7_decode u_dec_ones (
    .seg           (sample_q[6:0]),
    .blank_is_zero (1'b0),
    .legal         (ones_legal),
    .digit         (ones_digit)
  );

  assign legal     = tens_legal && ones_legal;
  assign new_score = 7'(tens_digit) * 7'd10 + 7'(ones_digit);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sample_q <= '0;
      cnt_q    <= '0;
    end else begin
      sample_q <= new_sample;
      if (changed) begin
        cnt_q <= '0;
      end else if (cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (changed) begin
      state_d = ST_SETTLE;
    end else if (accept) begin
      state_d = legal ? ST_LOCKED : ST_FAULT;
    end
  end

  // valid/err only move on acceptance, so they ride through SETTLE unchanged
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      score_o <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else if (accept) begin
      if (legal) begin
        score_o <= new_score;
        valid_o <= 1'b1;
        err_o   <= 1'b0;
      end else begin
        valid_o <= 1'b0;
        err_o   <= 1'b1;
      end
    end
  end

`ifdef SEG_MONITOR_EVENTS_EN
  logic inc_q, dec_q;

  // score_o is the previous accepted score; valid_o marks that it came from LOCKED
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      inc_q <= accept && legal && valid_o && (new_score == score_o + 7'd1);
      dec_q <= accept && legal && valid_o && (score_o != 7'd0) &&
               (new_score == score_o - 7'd1);
    end
  end

  assign inc_o = inc_q;
  assign dec_o = dec_q;
`else
  assign inc_o = 1'b0;
  assign dec_o = 1'b0;
`endif

endmodule

// File: tb/tb_seg_monitor.sv
// tb/tb_seg_monitor.sv - scoreboard bench for seg_monitor (pulse checks follow SEG_MONITOR_EVENTS_EN)
module tb_seg_monitor;
  import seg_pkg::*;

`ifdef SEG_MONITOR_EVENTS_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif

  typedef struct packed {
    logic [6:0] score;
    logic       valid;
    logic       err;
    logic       inc;
    logic       dec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_tens = 7'h00;
  logic [6:0] seg_ones = 7'h00;
  logic [6:0] score;
  logic       valid, err, inc, dec;

  int   total = 0;
  int   passed = 0;
  int   m_score = 0;
  bit   m_valid = 1'b0;
  bit   m_err = 1'b0;
  exp_t sb[$];

  seg_monitor #(.STABLE_CYCLES(4)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .seg_tens_i (seg_tens),
    .seg_ones_i (seg_ones),
    .score_o    (score),
    .valid_o    (valid),
    .err_o      (err),
    .inc_o      (inc),
    .dec_o      (dec)
  );

  always #5 clk = ~clk;

  function automatic int model_digit(input logic [6:0] p, input bit blank_ok);
    case (p)
      7'h3F: return 0;
      7'h06: return 1;
      7'h5B: return 2;
      7'h4F: return 3;
      7'h66: return 4;
      7'h6D: return 5;
      7'h7D: return 6;
      7'h07: return 7;
      7'h7F: return 8;
      7'h6F: return 9;
      7'h00: return blank_ok ? 0 : -1;
      default: return -1;
    endcase
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.score = score;
    o.valid = valid;
    o.err   = err;
    o.inc   = inc;
    o.dec   = dec;
    return o;
  endfunction

  function automatic exp_t cur_out();
    exp_t o;
    o.score = 7'(m_score);
    o.valid = m_valid;
    o.err   = m_err;
    o.inc   = 1'b0;
    o.dec   = 1'b0;
    return o;
  endfunction

  task automatic push_expected(input logic [6:0] t, input logic [6:0] o);
    exp_t e;
    int a, b, s;
    a = model_digit(t, 1'b1);
    b = model_digit(o, 1'b0);
    e.inc = 1'b0;
    e.dec = 1'b0;
    if (a >= 0 && b >= 0) begin
      s = a * 10 + b;
      e.inc = EV && m_valid && (s == m_score + 1);
      e.dec = EV && m_valid && (s == m_score - 1);
      m_score = s;
      m_valid = 1'b1;
      m_err = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_err = 1'b1;
    end
    e.score = 7'(m_score);
    e.valid = m_valid;
    e.err   = m_err;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [13:0] p);
    seg_tens = p[13:7];
    seg_ones = p[6:0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(14'h0);
    #12;
    total++;
    if (obs() !== exp_t'(0)) $display("FAIL reset_outputs: got %h, want %h", obs(), exp_t'(0));
    else passed++;
    total++;
    if (dut.state_q !== ST_WAIT) $display("FAIL reset_state: got %0d, want %0d", dut.state_q, ST_WAIT);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Runs a list of held patterns: unchanged outputs for 4 cycles, result on the 5th
  task automatic test_sequence(input string name, input logic [13:0] pats[$]);
    exp_t pre, e, want;
    e = '0;
    for (int i = 0; i < pats.size(); i++) begin
      pre = cur_out();
      drive(pats[i]);
      push_expected(pats[i][13:7], pats[i][6:0]);
      for (int c = 1; c <= 6; c++) begin
        tick();
        if (c == 5) e = sb.pop_front();
        want = (c < 5) ? pre : e;
        if (c == 6) begin
          want.inc = 1'b0;
          want.dec = 1'b0;
        end
        total++;
        if (obs() !== want) $display("FAIL %s pat%0d cyc%0d: got %h, want %h", name, i, c, obs(), want);
        else passed++;
      end
    end
  endtask

  task automatic test_hold_zero();
    logic [13:0] p[$];
    p = '{{7'h3F, 7'h3F}};
    test_sequence("hold_zero", p);
  endtask

  task automatic test_inc();
    logic [13:0] p[$];
    p = '{{7'h3F, 7'h06}};
    test_sequence("inc_00_01", p);
  endtask

  task automatic test_glitch();
    logic [13:0] p[$];
    exp_t want;
    p = '{{7'h66, 7'h5B}};
    test_sequence("glitch_setup", p);
    drive({7'h66, 7'h4F});
    for (int c = 1; c <= 3; c++) begin
      tick();
      want = cur_out();
      total++;
      if (obs() !== want) $display("FAIL glitch cyc%0d: got %h, want %h", c, obs(), want);
      else passed++;
    end
    test_sequence("glitch_revert", p);
  endtask

  task automatic test_illegal();
    logic [13:0] p[$];
    p = '{{7'h66, 7'h7A}, {7'h66, 7'h4F}};
    test_sequence("illegal", p);
  endtask

  task automatic test_dec_wrap();
    logic [13:0] p[$];
    p = '{{7'h6D, 7'h07}, {7'h6D, 7'h7D}, {7'h6F, 7'h6F}, {7'h3F, 7'h3F},
          {7'h00, 7'h06}, {7'h00, 7'h5B}, {7'h7F, 7'h7F}};
    test_sequence("dec_wrap", p);
  endtask

  task automatic test_async_reset();
    logic [13:0] p[$];
    drive({7'h4F, 7'h4F});
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== exp_t'(0)) $display("FAIL async_reset_outputs: got %h, want %h", obs(), exp_t'(0));
    else passed++;
    total++;
    if (dut.state_q !== ST_WAIT) $display("FAIL async_reset_state: got %0d, want %0d", dut.state_q, ST_WAIT);
    else passed++;
    m_score = 0;
    m_valid = 1'b0;
    m_err = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    p = '{{7'h4F, 7'h4F}};
    test_sequence("post_reset", p);
  endtask

  initial begin
    test_reset();
    test_hold_zero();
    test_inc();
    test_glitch();
    test_illegal();
    test_dec_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
